// File: rtl/gb_oam_dma.sv
// OAM DMA sequencer for the 0xFF46 register: copies LEN bytes from page P<<8 into OAM.
// Optional macro GB_OAM_DMA_BUSLOCK_EN drives cpu_block from active; otherwise cpu_block is tied 0.
module gb_oam_dma #(
  parameter int LEN          = 160,
  parameter int CYC_PER_BYTE = 4,
  parameter int START_DELAY  = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        reg_write,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [15:0] adr_dma,
  output logic        rd_dma,
  input  logic [7:0]  data_in,
  output logic [7:0]  oam_adr,
  output logic [7:0]  oam_data,
  output logic        oam_wr,
  active,
  output logic        cpu_block
);

  localparam int             PW       = $clog2(CYC_PER_BYTE);
  localparam logic [PW-1:0]  PH_LAST  = PW'(CYC_PER_BYTE - 1);
  localparam logic [PW-1:0]  PH_ADR   = PW'(0);
  localparam logic [PW-1:0]  PH_CAP   = PW'(1);
  localparam logic [PW-1:0]  PH_WR    = PW'(2);
  localparam logic [7:0]     IDX_LAST = 8'(LEN - 1);
  // The register-write cycle is the first delay cycle, so START itself lasts START_DELAY-1 cycles.
  localparam logic [7:0]     DLY_LOAD = 8'(START_DELAY - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    page, page_nxt;
  logic [7:0]    src, src_nxt;
  logic [7:0]    dly, dly_nxt;
  logic [7:0]    idx, idx_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic          keep_act, keep_act_nxt;
  logic          xfer;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      page     <= 8'h00;
      src      <= 8'h00;
      dly      <= 8'h00;
      idx      <= 8'h00;
      phase    <= '0;
      keep_act <= 1'b0;
      oam_data <= 8'h00;
    end else begin
      state    <= state_nxt;
      page     <= page_nxt;
      src      <= src_nxt;
      dly      <= dly_nxt;
      idx      <= idx_nxt;
      phase    <= phase_nxt;
      keep_act <= keep_act_nxt;
      if (xfer && (phase == PH_CAP)) oam_data <= data_in;
    end
  end

  always_comb begin
    state_nxt    = state;
    page_nxt     = page;
    src_nxt      = src;
    dly_nxt      = dly;
    idx_nxt      = idx;
    phase_nxt    = phase;
    keep_act_nxt = keep_act;
    if (reg_write) begin
      // Pages 0xE0-0xFF fold onto WRAM (echo region); readback keeps the raw value.
      page_nxt  = din;
      src_nxt   = (din >= 8'hE0) ? (din & 8'hDF) : din;
      dly_nxt   = DLY_LOAD;
      state_nxt = START;
      case (state)
        IDLE:    keep_act_nxt = 1'b0;
        XFER:    keep_act_nxt = 1'b1;
        default: keep_act_nxt = keep_act;
      endcase
    end else begin
      case (state)
        START: begin
          if (dly == 8'h00) begin
            state_nxt = XFER;
            idx_nxt   = 8'h00;
            phase_nxt = '0;
          end else begin
            dly_nxt = dly - 8'h01;
          end
        end
        XFER: begin
          if (phase == PH_LAST) begin
            phase_nxt = '0;
            if (idx == IDX_LAST) begin
              state_nxt    = IDLE;
              keep_act_nxt = 1'b0;
            end else begin
              idx_nxt = idx + 8'h01;
            end
          end else begin
            phase_nxt = phase + PW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Bus strobes: rd_dma holds the address for phases 0-1, data_in is sampled at the end of
  // phase 1, and oam_wr is a single-cycle pulse in phase 2 cancelled by a coincident restart.
  assign xfer      = (state == XFER);
  assign dout      = page;
  assign adr_dma   = xfer ? {src, idx} : 16'h0000;
  assign rd_dma    = xfer && ((phase == PH_ADR) || (phase == PH_CAP));
  assign oam_adr   = xfer ? idx : 8'h00;
  assign oam_wr    = xfer && (phase == PH_WR) && !reg_write;
  assign active    = xfer || ((state == START) && keep_act);

`ifdef GB_OAM_DMA_BUSLOCK_EN
  assign cpu_block = active;
`else
  assign cpu_block = 1'b0;
`endif

endmodule

// File: tb/tb_gb_oam_dma.sv
// Self-checking bench for gb_oam_dma: per-cycle comparison against a timeline model of the transfer.
module tb_gb_oam_dma;

  localparam int LEN = 160;
  localparam int CPB = 4;
  localparam int SD  = 4;
  localparam int XL  = LEN * CPB;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        reg_write = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  dout;
  logic [15:0] adr_dma;
  logic        rd_dma;
  logic [7:0]  oam_adr;
  logic [7:0]  oam_data;
  logic        oam_wr;
  logic        active;
  logic        cpu_block;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [0:65535];
  int          wt[$];
  logic [7:0]  wp[$];
  logic        last_rd = 1'b0;
  logic [15:0] last_adr = 16'h0000;
  int          wr_pulses;
  int          act_cycles;

  always #5 clk = ~clk;

  gb_oam_dma #(.LEN(LEN), .CYC_PER_BYTE(CPB), .START_DELAY(SD)) dut (
    .clk(clk), .n_reset(n_reset), .reg_write(reg_write), .din(din), .dout(dout),
    .adr_dma(adr_dma), .rd_dma(rd_dma), .data_in(data_in), .oam_adr(oam_adr),
    .oam_data(oam_data), .oam_wr(oam_wr), .active(active), .cpu_block(cpu_block)
  );

  function automatic logic [7:0] fold(input logic [7:0] p);
    return (p >= 8'hE0) ? (p & 8'hDF) : p;
  endfunction

  // active during the START that follows write j: the previous transfer was copying at that moment,
  // or it was itself in a START that was already showing active.
  function automatic bit start_active(input int j);
    bit a = 1'b0;
    int off;
    for (int k = 1; k <= j; k++) begin
      off = wt[k] - wt[k-1] - SD;
      if (off >= 0) a = (off < XL);
    end
    return a;
  endfunction

  task automatic expect_at(input int c, output logic [3:0] flags, output logic [15:0] adr,
                           output logic [7:0] oadr, output logic [7:0] odata);
    int j = -1;
    int off;
    bit wr_now = 1'b0;
    logic act = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [7:0] s;
    adr = 16'h0000; oadr = 8'h00; odata = 8'h00;
    foreach (wt[k]) begin
      if (wt[k] < c) j = k;
      if (wt[k] == c) wr_now = 1'b1;
    end
    if (j >= 0) begin
      s   = fold(wp[j]);
      off = c - wt[j] - SD;
      if (off < 0) begin
        act = start_active(j);
      end else if (off < XL) begin
        act = 1'b1;
        rd  = ((off % CPB) < 2);
        wr  = ((off % CPB) == 2) && !wr_now;
        adr   = rd ? {s, 8'(off / CPB)} : 16'h0000;
        oadr  = wr ? 8'(off / CPB) : 8'h00;
        odata = wr ? mem[{s, 8'(off / CPB)}] : 8'h00;
      end
    end
`ifdef GB_OAM_DMA_BUSLOCK_EN
    flags = {act, rd, wr, act};
`else
    flags = {act, rd, wr, 1'b0};
`endif
  endtask

  task automatic run_cycles(input int n, input string tag);
    logic [3:0]  ef;
    logic [15:0] ea;
    logic [7:0]  eo, ed;
    logic [39:0] exp_v, obs_v;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      data_in   = last_rd ? mem[last_adr] : 8'h00;
      reg_write = 1'b0;
      din       = 8'($urandom_range(0, 255));
      foreach (wt[k]) if (wt[k] == c) begin reg_write = 1'b1; din = wp[k]; end
      @(negedge clk);
      expect_at(c, ef, ea, eo, ed);
      exp_v = {ef, ea, eo, ed};
      obs_v = {active, rd_dma, oam_wr, cpu_block, ef[2] ? adr_dma : 16'h0000,
               ef[1] ? oam_adr : 8'h00, ef[1] ? oam_data : 8'h00};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL %s cyc=%0d act/rd/wr/cb=%b adr=%h oadr=%h data=%h required %b %h %h %h",
                 tag, c, obs_v[39:36], obs_v[35:20], obs_v[15:8], obs_v[7:0], ef, ea, eo, ed);
      end
      wr_pulses  += int'(oam_wr);
      act_cycles += int'(active);
      last_rd  = rd_dma;
      last_adr = adr_dma;
    end
  endtask

  task automatic new_scenario();
    wt.delete(); wp.delete();
    wr_pulses = 0; act_cycles = 0;
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] exp_dout);
    logic [44:0] obs_v, exp_v;
    obs_v = {active, rd_dma, oam_wr, cpu_block, dout, adr_dma, oam_adr, oam_data};
    exp_v = {4'b0000, exp_dout, 16'h0000, 8'h00, 8'h00};
    checks++;
    if (obs_v !== exp_v) begin
      errors++;
      $display("FAIL %s act/rd/wr/cb=%b dout=%h adr=%h oadr=%h data=%h required zeros dout=%h",
               tag, obs_v[44:41], dout, adr_dma, oam_adr, oam_data, exp_dout);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", tag, got, req);
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_state", 8'h00);
    #2 n_reset = 1'b1;
    new_scenario();
    run_cycles(10, "idle_after_reset");
  endtask

  task automatic test_basic();
    new_scenario();
    wt.push_back(2); wp.push_back(8'hC1);
    run_cycles(2 + SD + XL + 10, "basic_c1");
    check_val("basic_wr_pulses", wr_pulses, LEN);
    check_val("basic_active_cycles", act_cycles, XL);
    check_val("basic_dout", int'(dout), 8'hC1);
  endtask

  task automatic test_echo();
    new_scenario();
    wt.push_back(2); wp.push_back(8'hF3);
    run_cycles(2 + SD + XL + 10, "echo_f3");
    check_val("echo_dout", int'(dout), 8'hF3);
    check_val("echo_wr_pulses", wr_pulses, LEN);
  endtask

  task automatic test_restart();
    new_scenario();
    wt.push_back(1);                    wp.push_back(8'hC0);
    wt.push_back(1 + SD + 50 * CPB + 1); wp.push_back(8'hC8);
    run_cycles(wt[1] + SD + XL + 10, "restart_b50");
    check_val("restart_wr_pulses", wr_pulses, 50 + LEN);
    check_val("restart_dout", int'(dout), 8'hC8);
  endtask

  task automatic test_last_phase();
    new_scenario();
    wt.push_back(1);            wp.push_back(8'h80);
    wt.push_back(1 + SD + XL - 1); wp.push_back(8'h81);
    run_cycles(wt[1] + SD + XL + 10, "restart_last_phase");
  endtask

  task automatic test_back_to_back();
    new_scenario();
    wt.push_back(1);         wp.push_back(8'h12);
    wt.push_back(1 + SD + XL); wp.push_back(8'hE5);
    run_cycles(wt[1] + SD + XL + 10, "back_to_back");
    check_val("b2b_wr_pulses", wr_pulses, 2 * LEN);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      new_scenario();
      wt.push_back(1); wp.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) != 0) begin
        wt.push_back($urandom_range(2, 1 + SD + XL + 2));
        wp.push_back(8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 1) != 0) begin
        wt.push_back(wt[wt.size()-1] + $urandom_range(1, SD + 2));
        wp.push_back(8'($urandom_range(0, 255)));
      end
      run_cycles(wt[wt.size()-1] + SD + XL + 8, "random");
    end
  endtask

  task automatic test_reset_mid();
    new_scenario();
    wt.push_back(1); wp.push_back(8'hC4);
    run_cycles(1 + SD + 100 * CPB + 1, "pre_reset");
    @(posedge clk); #1;
    reg_write = 1'b0;
    n_reset = 1'b0;
    #1;
    check_idle_outputs("reset_mid_async", 8'h00);
    @(negedge clk);
    check_idle_outputs("reset_mid_held", 8'h00);
    #2 n_reset = 1'b1;
    last_rd = 1'b0;
    new_scenario();
    run_cycles(40, "after_mid_reset");
    check_val("after_reset_dout", int'(dout), 0);
  endtask

  initial begin
    foreach (mem[a]) mem[a] = 8'($urandom_range(0, 255));
    test_reset();
    test_basic();
    test_echo();
    test_restart();
    test_last_phase();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
